// File: rtl/rf_pkg.sv
// Shared register-file constants and the write-queue entry type.
package rf_pkg;

    localparam int unsigned REG_COUNT = 15;  // architectural registers 0..14
    localparam int unsigned PC_IDX    = 15;  // PC index, not held in the register file
    localparam int unsigned ADDR_W    = 4;
    localparam int unsigned DATA_W    = 32;

    typedef struct packed {
        logic [ADDR_W-1:0] dest;
        logic [DATA_W-1:0] data;
    } wq_entry_t;

    // True when a destination names the PC rather than a file register.
    function automatic logic is_pc(input logic [ADDR_W-1:0] dest);
        return dest == ADDR_W'(PC_IDX);
    endfunction

endpackage

// File: rtl/reg_write_queue_if.sv
// Writeback-lane, register-file write port and hazard-query bundle.
interface reg_write_queue_if;
    import rf_pkg::*;

    logic                 wa_valid;
    logic [ADDR_W-1:0]    wa_dest;
    logic [DATA_W-1:0]    wa_data;
    logic                 wb_valid;
    logic [ADDR_W-1:0]    wb_dest;
    logic [DATA_W-1:0]    wb_data;
    logic                 in_ready;
    logic                 flush;
    logic                 reg_write;
    logic [ADDR_W-1:0]    reg_dest;
    logic [DATA_W-1:0]    data;
    logic [ADDR_W-1:0]    src1;
    logic [ADDR_W-1:0]    src2;
    logic                 hazard1;
    logic                 hazard2;
    logic [REG_COUNT-1:0] pending;

    // Producer / hazard-unit side.
    modport master (
        output wa_valid, wa_dest, wa_data, wb_valid, wb_dest, wb_data, flush, src1, src2,
        input  in_ready, reg_write, reg_dest, data, hazard1, hazard2, pending
    );

    // Queue side.
    modport slave (
        input  wa_valid, wa_dest, wa_data, wb_valid, wb_dest, wb_data, flush, src1, src2,
        output in_ready, reg_write, reg_dest, data, hazard1, hazard2, pending
    );

endinterface

// File: rtl/wq_fifo.sv
// Dual-push, single-pop FIFO of pending register writes with per-entry valid bits.
module wq_fifo
    import rf_pkg::*;
#(
    parameter int unsigned  DEPTH = 4,
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           push_a,
    input  wq_entry_t                      entry_a,
    input  logic                           push_b,
    input  wq_entry_t                      entry_b,
    input  logic                           pop,
    input  logic                           flush,
    output wq_entry_t                      head,
    output logic [CNT_W-1:0]               count,
    output logic [DEPTH-1:0]               valid,
    output logic [DEPTH-1:0][ADDR_W-1:0]   dests
);

    logic [PTR_W-1:0] rd_q, rd_d, wr_q, wr_d, wr_b;
    logic [CNT_W-1:0] count_q, count_d;
    logic [DEPTH-1:0] valid_q, valid_d;
    wq_entry_t        mem_q [DEPTH];

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (32'(p) == DEPTH - 1) ? '0 : p + 1'b1;
    endfunction

    // Next pointers, occupancy and valid bits; lane B lands behind lane A when both push.
    always_comb begin
        wr_b    = push_a ? ptr_inc(wr_q) : wr_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        valid_d = valid_q;
        count_d = count_q + CNT_W'(push_a) + CNT_W'(push_b) - CNT_W'(pop);
        if (flush) begin
            wr_d    = '0;
            rd_d    = '0;
            valid_d = '0;
            count_d = '0;
        end else begin
            if (pop) begin
                valid_d[rd_q] = 1'b0;
                rd_d          = ptr_inc(rd_q);
            end
            if (push_a) valid_d[wr_q] = 1'b1;
            if (push_b) valid_d[wr_b] = 1'b1;
            if (push_b) begin
                wr_d = ptr_inc(wr_b);
            end else if (push_a) begin
                wr_d = ptr_inc(wr_q);
            end
        end
    end

    // Pointer, occupancy and valid-bit state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_q    <= '0;
            wr_q    <= '0;
            count_q <= '0;
            valid_q <= '0;
        end else begin
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            count_q <= count_d;
            valid_q <= valid_d;
        end
    end

    // Entry payload storage; contents are qualified by valid_q so need no reset.
    always_ff @(posedge clk) begin
        if (push_a && !flush) mem_q[wr_q] <= entry_a;
        if (push_b && !flush) mem_q[wr_b] <= entry_b;
    end

    // Expose head, occupancy and every entry's destination to the scoreboard.
    always_comb begin
        head  = mem_q[rd_q];
        count = count_q;
        valid = valid_q;
        for (int i = 0; i < DEPTH; i++) dests[i] = mem_q[i].dest;
    end

`ifndef SYNTHESIS
    count_overflow: assert property (@(posedge clk) disable iff (!rst) 32'(count_q) <= DEPTH);
`endif

endmodule

// File: rtl/reg_write_queue.sv
// Serialises up to two writeback writes per cycle onto the register file's single write
// port, in program order, and publishes a pending-destination scoreboard for hazards.
module reg_write_queue
    import rf_pkg::*;
#(
    parameter int unsigned  DEPTH = 4,  // must be >= 2 so a dual write always fits
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input logic              clk,
    input logic              rst,
    reg_write_queue_if.slave bus
);

    logic                         in_ready, push_a, push_b, pop;
    wq_entry_t                    entry_a, entry_b, head;
    logic [CNT_W-1:0]             count;
    logic [DEPTH-1:0]             valid;
    logic [DEPTH-1:0][ADDR_W-1:0] dests;
    logic                         reg_write_q;
    logic [ADDR_W-1:0]            reg_dest_q;
    logic [DATA_W-1:0]            data_q;
    logic [REG_COUNT-1:0]         pending;

    // Lane acceptance; readiness ignores a same-cycle pop, and PC writes are swallowed.
    always_comb begin
        in_ready = ((DEPTH - 32'(count)) >= 2) && !bus.flush;
        push_a   = bus.wa_valid && in_ready && !is_pc(bus.wa_dest);
        push_b   = bus.wb_valid && in_ready && !is_pc(bus.wb_dest);
        entry_a  = '{dest: bus.wa_dest, data: bus.wa_data};
        entry_b  = '{dest: bus.wb_dest, data: bus.wb_data};
        pop      = (count != '0) && !bus.flush;
    end

    wq_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_a  (push_a),
        .entry_a (entry_a),
        .push_b  (push_b),
        .entry_b (entry_b),
        .pop     (pop),
        .flush   (bus.flush),
        .head    (head),
        .count   (count),
        .valid   (valid),
        .dests   (dests)
    );

    // Issue register: load the head on pop; dest/data hold while idle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            reg_write_q <= 1'b0;
            reg_dest_q  <= '0;
            data_q      <= '0;
        end else if (pop) begin
            reg_write_q <= 1'b1;
            reg_dest_q  <= head.dest;
            data_q      <= head.data;
        end else begin
            reg_write_q <= 1'b0;
        end
    end

    // Scoreboard: queued entries plus the write sitting in the issue register.
    always_comb begin
        pending = '0;
        for (int r = 0; r < REG_COUNT; r++) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (valid[i] && dests[i] == ADDR_W'(r)) pending[r] = 1'b1;
            end
            if (reg_write_q && reg_dest_q == ADDR_W'(r)) pending[r] = 1'b1;
        end
    end

    // Drive the port bundle; PC queries never report a hazard.
    always_comb begin
        bus.in_ready  = in_ready;
        bus.reg_write = reg_write_q;
        bus.reg_dest  = reg_dest_q;
        bus.data      = data_q;
        bus.pending   = pending;
        bus.hazard1   = is_pc(bus.src1) ? 1'b0 : pending[bus.src1];
        bus.hazard2   = is_pc(bus.src2) ? 1'b0 : pending[bus.src2];
    end

endmodule

// File: tb/tb_reg_write_queue.sv
// Directed bench for reg_write_queue with a queue-level reference model.
module tb_reg_write_queue;
    import rf_pkg::*;

    localparam int unsigned DEPTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    reg_write_queue_if bus();

    reg_write_queue #(
        .DEPTH (DEPTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        logic [3:0]  dest;
        logic [31:0] data;
    } ment_t;

    ment_t       mq[$];
    logic        m_wr   = 1'b0;
    logic [3:0]  m_dest = '0;
    logic [31:0] m_data = '0;
    logic        m_rdy;
    logic [31:0] mrf [16];
    logic [31:0] drf [16];
    logic [14:0] ep;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [14:0] exp_pending();
        logic [14:0] p = '0;
        foreach (mq[i]) p[mq[i].dest] = 1'b1;
        if (m_wr) p[m_dest] = 1'b1;
        return p;
    endfunction

    // Reference model: a plain FIFO of writes plus the one-entry output stage.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            mq.delete();
            m_wr   = 1'b0;
            m_dest = '0;
            m_data = '0;
        end else begin
            m_rdy = ((int'(DEPTH) - mq.size()) >= 2) && !bus.flush;
            if (bus.flush) begin
                mq.delete();
                m_wr = 1'b0;
            end else begin
                if (mq.size() > 0) begin
                    m_wr   = 1'b1;
                    m_dest = mq[0].dest;
                    m_data = mq[0].data;
                    void'(mq.pop_front());
                end else begin
                    m_wr = 1'b0;
                end
                if (m_rdy) begin
                    if (bus.wa_valid && bus.wa_dest != 4'd15) mq.push_back('{bus.wa_dest, bus.wa_data});
                    if (bus.wb_valid && bus.wb_dest != 4'd15) mq.push_back('{bus.wb_dest, bus.wb_data});
                end
            end
        end
    end

    // Every-cycle compare on the falling edge, then commit into both register-file images.
    always @(negedge clk) begin
        if (rst) begin
            ep = exp_pending();
            chk("reg_write", 64'(bus.reg_write), 64'(m_wr));
            chk("reg_dest", 64'(bus.reg_dest), 64'(m_dest));
            chk("data", 64'(bus.data), 64'(m_data));
            chk("in_ready", 64'(bus.in_ready),
                64'(((int'(DEPTH) - mq.size()) >= 2) && !bus.flush));
            chk("pending", 64'(bus.pending), 64'(ep));
            chk("hazard1", 64'(bus.hazard1), 64'((bus.src1 == 4'd15) ? 1'b0 : ep[bus.src1]));
            chk("hazard2", 64'(bus.hazard2), 64'((bus.src2 == 4'd15) ? 1'b0 : ep[bus.src2]));
            if (m_wr) mrf[m_dest] = m_data;
            if (bus.reg_write) drf[bus.reg_dest] = bus.data;
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic lanes(input logic va, input logic [3:0] da, input logic [31:0] xa,
                         input logic vb, input logic [3:0] db, input logic [31:0] xb);
        bus.wa_valid = va; bus.wa_dest = da; bus.wa_data = xa;
        bus.wb_valid = vb; bus.wb_dest = db; bus.wb_data = xb;
    endtask

    task automatic idle();
        bus.wa_valid = 1'b0;
        bus.wb_valid = 1'b0;
        bus.flush    = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            mrf[i] = '0;
            drf[i] = '0;
        end
        lanes(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0);
        bus.flush = 1'b0;
        bus.src1  = 4'd3;
        bus.src2  = 4'd7;
        repeat (2) step();
        rst = 1'b1;
        #1;
        chk("rst reg_write", 64'(bus.reg_write), 64'd0);
        chk("rst reg_dest", 64'(bus.reg_dest), 64'd0);
        chk("rst data", 64'(bus.data), 64'd0);
        chk("rst pending", 64'(bus.pending), 64'd0);
        chk("rst in_ready", 64'(bus.in_ready), 64'd1);

        // Single write
        lanes(1'b1, 4'd3, 32'hDEADBEEF, 1'b0, 4'd0, 32'd0);
        step();
        idle();
        chk("t1 pending", 64'(bus.pending), 64'h0008);
        chk("t1 no early write", 64'(bus.reg_write), 64'd0);
        step();
        chk("t1 reg_write", 64'(bus.reg_write), 64'd1);
        chk("t1 reg_dest", 64'(bus.reg_dest), 64'd3);
        chk("t1 data", 64'(bus.data), 64'hDEADBEEF);
        chk("t1 hazard1", 64'(bus.hazard1), 64'd1);
        step();
        chk("t1 drop", 64'(bus.reg_write), 64'd0);
        chk("t1 pending clear", 64'(bus.pending), 64'd0);

        // Dual write every cycle
        lanes(1'b1, 4'd1, 32'h11, 1'b1, 4'd2, 32'h22);
        step();
        chk("t2 ready e0", 64'(bus.in_ready), 64'd1);
        step();
        chk("t2 ready e1", 64'(bus.in_ready), 64'd0);
        chk("t2 order e1", 64'(bus.reg_dest), 64'd1);
        step();
        chk("t2 order e2", 64'(bus.reg_dest), 64'd2);
        step();
        chk("t2 order e3", 64'(bus.reg_dest), 64'd1);
        idle();
        repeat (6) step();

        // Same destination twice
        bus.src1 = 4'd5;
        lanes(1'b1, 4'd5, 32'hA, 1'b1, 4'd5, 32'hB);
        step();
        idle();
        chk("t3 hazard q", 64'(bus.hazard1), 64'd1);
        step();
        chk("t3 data A", 64'(bus.data), 64'hA);
        chk("t3 hazard A", 64'(bus.hazard1), 64'd1);
        step();
        chk("t3 data B", 64'(bus.data), 64'hB);
        chk("t3 hazard B", 64'(bus.hazard1), 64'd1);
        step();
        chk("t3 retired", 64'(bus.hazard1), 64'd0);
        chk("t3 rf5", 64'(drf[5]), 64'hB);
        chk("t3 model rf5", 64'(mrf[5]), 64'hB);

        // PC destination
        bus.src1 = 4'd15;
        bus.src2 = 4'd7;
        lanes(1'b1, 4'd15, 32'h40, 1'b1, 4'd7, 32'h70);
        step();
        idle();
        chk("t4 pending", 64'(bus.pending), 64'h0080);
        chk("t4 hazard pc", 64'(bus.hazard1), 64'd0);
        chk("t4 hazard 7", 64'(bus.hazard2), 64'd1);
        step();
        chk("t4 reg_dest", 64'(bus.reg_dest), 64'd7);
        chk("t4 data", 64'(bus.data), 64'h70);
        step();
        chk("t4 drop", 64'(bus.reg_write), 64'd0);

        // Flush with three queued and one issued
        bus.src1 = 4'd3;
        bus.src2 = 4'd4;
        lanes(1'b1, 4'd1, 32'h101, 1'b1, 4'd2, 32'h102);
        step();
        lanes(1'b1, 4'd3, 32'h103, 1'b1, 4'd4, 32'h104);
        step();
        chk("t5 issued", 64'(bus.reg_write), 64'd1);
        chk("t5 issued dest", 64'(bus.reg_dest), 64'd1);
        lanes(1'b1, 4'd6, 32'h106, 1'b0, 4'd0, 32'd0);
        bus.flush = 1'b1;
        #1;
        chk("t5 ready flush", 64'(bus.in_ready), 64'd0);
        step();
        idle();
        chk("t5 reg_write", 64'(bus.reg_write), 64'd0);
        chk("t5 pending", 64'(bus.pending), 64'd0);
        chk("t5 rf1", 64'(drf[1]), 64'h101);
        repeat (3) begin
            step();
            chk("t5 quiet", 64'(bus.reg_write), 64'd0);
        end
        chk("t5 rf4 untouched", 64'(drf[4]), 64'd0);
        chk("t5 rf6 dropped", 64'(drf[6]), 64'd0);

        // Asynchronous reset mid-drain
        lanes(1'b1, 4'd8, 32'h800, 1'b1, 4'd9, 32'h900);
        step();
        lanes(1'b1, 4'd10, 32'hA00, 1'b1, 4'd11, 32'hB00);
        step();
        idle();
        step();
        chk("t6 draining", 64'(bus.reg_dest), 64'd9);
        rst = 1'b0;
        #1;
        chk("t6 async drop", 64'(bus.reg_write), 64'd0);
        chk("t6 async pending", 64'(bus.pending), 64'd0);
        step();
        rst = 1'b1;
        #1;
        chk("t6 ready", 64'(bus.in_ready), 64'd1);
        step();
        chk("t6 idle", 64'(bus.reg_write), 64'd0);
        chk("t6 rf10", 64'(drf[10]), 64'd0);

        // Mixed traffic with occasional flush
        bus.src1 = 4'd2;
        bus.src2 = 4'd15;
        for (int n = 0; n < 60; n++) begin
            lanes(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom,
                  1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom);
            bus.flush = ($urandom_range(0, 9) == 0);
            bus.src1  = 4'($urandom_range(0, 15));
            step();
        end
        idle();
        repeat (6) step();
        for (int i = 0; i < 15; i++) chk("final rf", 64'(drf[i]), 64'(mrf[i]));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/reg_write_queue.md
Name: reg_write_queue

Overview:
- Producer-side front end for the 15-entry register file's write port (reg_write / reg_dest / data).
- Accepts up to two register writes per cycle from the writeback stage. Two writes arise from an SRAM load with base writeback (Rd plus Rn).
- Serialises them into the register file's single write port, one write per cycle, in program order.
- Publishes a pending-destination scoreboard so the hazard unit stalls readers of registers whose writes have not yet committed.

Parameters:
- DEPTH, 4, queue entries; must be >= 2.
- DATA_W, 32, write data width.
- ADDR_W, 4, register index width.
- NUM_REGS, 15, number of architectural registers held in the register file (indices 0..14).

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  asynchronous, active-low reset.
- wa_valid  in  1  lane A write request.
- wa_dest  in  ADDR_W  lane A destination.
- wa_data  in  DATA_W  lane A data.
- wb_valid  in  1  lane B write request; program-order younger than lane A.
- wb_dest  in  ADDR_W  lane B destination.
- wb_data  in  DATA_W  lane B data.
- in_ready  out  1  both lanes may be accepted this cycle.
- flush  in  1  discard all queued, not-yet-issued writes.
- reg_write  out  1  write strobe to the register file (registered).
- reg_dest  out  ADDR_W  write index to the register file (registered).
- data  out  DATA_W  write data to the register file (registered).
- src1  in  ADDR_W  hazard query index 1.
- src2  in  ADDR_W  hazard query index 2.
- hazard1  out  1  src1 has a pending write (combinational).
- hazard2  out  1  src2 has a pending write (combinational).
- pending  out  NUM_REGS  per-register pending-write mask (combinational).

Behaviour:
- Reset (rst=0, asynchronous):
  - count=0, rd/wr pointers=0.
  - reg_write=0, reg_dest=0, data=0, pending=0.
  - in_ready=1 once rst deasserts.
- in_ready = (DEPTH - count >= 2) && !flush, where count is the registered occupancy. in_ready does not take credit for a same-cycle pop.
- Accept:
  - A lane with valid=1 is accepted only when in_ready=1; a valid lane while in_ready=0 is ignored, and the producer holds it.
  - If both lanes are valid, A is enqueued before B. If only B is valid, it occupies one slot.
  - A dest of 15 (PC, not held in the register file) is accepted, not enqueued, and never sets pending.
- Issue:
  - At each posedge, if count>0 (pre-push) and no flush, load reg_write=1 and reg_dest/data from the head, then pop.
  - Otherwise reg_write<=0; reg_dest/data hold their value.
- Latency: a write accepted at edge N into an empty queue appears on reg_write at edge N+1. The register file commits it on the following negedge.
- Simultaneous push and pop in one cycle:
  - count_next = count + pushes - pop.
  - A push into an empty queue is not issued in the same edge (no bypass).
- pending[r] = OR over all valid queue entries with dest==r, OR (reg_write && reg_dest==r).
  - The output register counts as pending until the cycle after it drops.
  - hazard1 = pending[src1]; hazard2 = pending[src2].
  - src==15 gives hazard=0.
- Ordering: writes issue strictly FIFO. Repeated writes to one register commit oldest first, so the last write wins.
- Flush:
  - At the posedge with flush=1: count<=0, pointers reset, no pop, reg_write<=0.
  - A write already in the output register when flush rises still commits, because it has been issued.
  - Lanes presented in the flush cycle are dropped; in_ready=0 signals this.
- Pointers wrap modulo DEPTH. count never exceeds DEPTH; an assertion flags overflow.
- Mid-operation reset drops all queued writes and clears reg_write immediately (asynchronous).

Decomposition:
- Shared package rf_pkg:
  - constants REG_COUNT=15, PC_IDX=15, ADDR_W, DATA_W.
  - typedef wq_entry_t {dest, data}.
- One sub-module wq_fifo holds storage, pointers, count and per-entry valid bits, and exposes head, count and entry dests. reg_write_queue adds lane packing, the issue register, flush and the scoreboard.

Test Plan:
- Single write: A={dest 3, 0xDEADBEEF} at edge 0 -> reg_write=1, reg_dest=3, data=0xDEADBEEF after edge 1 only. pending[3]=1 from edge 0 until reg_write drops after edge 2.
- Dual write each cycle, DEPTH=4:
  - A/B={1,0x11},{2,0x22} every cycle -> in_ready falls after edge 1 (count 3).
  - Issued order is 1,2,1,2,…; no entry is lost or duplicated.
- Same destination: A={5,0xA}, B={5,0xB} -> two consecutive writes; data 0xA then 0xB; register 5 ends at 0xB. hazard1 with src1=5 stays high until the last write is retired.
- PC destination: A={15,0x40}, B={7,0x70} -> only dest 7 is issued; pending[14:0] never has a bit for 15; hazard with src=15 stays 0.
- Flush with 3 queued and one in the output register -> the output write completes. No further reg_write. pending=0 after the next edge. in_ready=0 during the flush cycle.
- Async reset asserted mid-drain -> reg_write=0 immediately, without waiting for clk. After release: count=0, in_ready=1.
